// File: rtl/fp_mult_pkg.sv
// Shared types, default widths and encoding helpers for the pipelined floating-point multiplier.
package fp_mult_pkg;

  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;
  localparam int FP_MAX_W = 128;

  typedef enum logic [1:0] {FP_ZERO, FP_NORM, FP_INF, FP_NAN} fp_class_e;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Denormal inputs land in FP_ZERO: they are flushed before any arithmetic.
  function automatic fp_class_e fp_classify(input logic exp_zero,
                                            input logic exp_ones,
                                            input logic frac_zero);
    if (exp_zero) return FP_ZERO;
    if (exp_ones) return frac_zero ? FP_INF : FP_NAN;
    return FP_NORM;
  endfunction

  function automatic fp_class_e fp_mul_class(input fp_class_e ca, input fp_class_e cb);
    if (ca == FP_NAN || cb == FP_NAN) return FP_NAN;
    if ((ca == FP_ZERO && cb == FP_INF) || (ca == FP_INF && cb == FP_ZERO)) return FP_NAN;
    if (ca == FP_INF || cb == FP_INF) return FP_INF;
    if (ca == FP_ZERO || cb == FP_ZERO) return FP_ZERO;
    return FP_NORM;
  endfunction

  function automatic logic [FP_MAX_W-1:0] fp_qnan(input int exp_w, input int man_w);
    logic [FP_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < exp_w; i++) r[man_w + i] = 1'b1;
    r[man_w - 1] = 1'b1;
    return r;
  endfunction

  function automatic logic [FP_MAX_W-1:0] fp_inf(input logic sign, input int exp_w, input int man_w);
    logic [FP_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < exp_w; i++) r[man_w + i] = 1'b1;
    r[exp_w + man_w] = sign;
    return r;
  endfunction

endpackage

// File: rtl/fp_norm_round.sv
// Third-stage core of fp_mult_pipe: normalise, round, pack and resolve special cases.
// FP_MULT_RNE_EN selects round-to-nearest-even; without it the fraction is truncated.
module fp_norm_round
  import fp_mult_pkg::*;
#(
  parameter int EXP_W = FP_EXP_W,
  parameter int MAN_W = FP_MAN_W
) (
  input  logic [2*MAN_W+1:0]       mprod,
  input  logic [EXP_W+1:0]         exp_sum,
  input  logic                     sign,
  input  fp_class_e                cls,
  output logic [EXP_W+MAN_W:0]     product,
  output logic                     overflow,
  output logic                     underflow,
  output logic                     infinity,
  output logic                     nan
);

  localparam int W = EXP_W + MAN_W + 1;
  localparam logic [EXP_W+1:0] EXP_MAX = (EXP_W+2)'((1 << EXP_W) - 1);
  localparam logic [W-1:0]     QNAN    = W'(fp_qnan(EXP_W, MAN_W));

  logic               msb;
  logic               inc;
  logic               carry;
  logic [MAN_W-1:0]   frac;
  logic [MAN_W:0]     frac_r;
  logic [EXP_W+1:0]   exp_f;

  assign msb  = mprod[2*MAN_W+1];
  assign frac = msb ? mprod[2*MAN_W:MAN_W+1] : mprod[2*MAN_W-1:MAN_W];

`ifdef FP_MULT_RNE_EN
  logic g;
  logic s;
  assign g   = msb ? mprod[MAN_W] : mprod[MAN_W-1];
  assign s   = msb ? |mprod[MAN_W-1:0] : |mprod[MAN_W-2:0];
  assign inc = g & (s | frac[0]);
`else
  logic unused_lsbs;
  assign unused_lsbs = ^mprod[MAN_W-1:0];
  assign inc = 1'b0;
`endif

  // A carry out of the fraction means 1.11..1 rounded up to 10.00..0: fraction is already zero.
  assign frac_r = {1'b0, frac} + (MAN_W+1)'(inc);
  assign carry  = frac_r[MAN_W];
  assign exp_f  = exp_sum + (EXP_W+2)'(msb) + (EXP_W+2)'(carry);

  always_comb begin
    product   = '0;
    overflow  = 1'b0;
    underflow = 1'b0;
    infinity  = 1'b0;
    nan       = 1'b0;
    if (cls == FP_NAN) begin
      product = QNAN;
      nan     = 1'b1;
    end else if (cls == FP_INF) begin
      product  = W'(fp_inf(sign, EXP_W, MAN_W));
      infinity = 1'b1;
    end else if (cls == FP_ZERO) begin
      product = {sign, {(W-1){1'b0}}};
    end else if (!exp_f[EXP_W+1] && exp_f >= EXP_MAX) begin
      product  = W'(fp_inf(sign, EXP_W, MAN_W));
      overflow = 1'b1;
      infinity = 1'b1;
    end else if (exp_f[EXP_W+1] || exp_f == '0) begin
      product   = {sign, {(W-1){1'b0}}};
      underflow = 1'b1;
    end else begin
      product = {sign, exp_f[EXP_W-1:0], frac_r[MAN_W-1:0]};
    end
  end

endmodule

// File: rtl/fp_mult_pipe.sv
// Three-stage streaming floating-point multiplier (classify, multiply, normalise/round) with valid/ready.
// Rounding mode follows FP_MULT_RNE_EN inside fp_norm_round; the default build truncates.
module fp_mult_pipe
  import fp_mult_pkg::*;
#(
  parameter int EXP_W = FP_EXP_W,
  parameter int MAN_W = FP_MAN_W
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  inValid,
  output logic                  inReady,
  input  logic [EXP_W+MAN_W:0]  a,
  input  logic [EXP_W+MAN_W:0]  b,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [EXP_W+MAN_W:0]  product,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  infinity,
  output logic                  NAN
);

  localparam int W  = EXP_W + MAN_W + 1;
  localparam int PW = 2*MAN_W + 2;
  localparam logic [EXP_W+1:0] BIAS = (EXP_W+2)'(fp_bias(EXP_W));

  logic advance;

  // One global enable: the whole pipe, bubbles included, freezes while the output is blocked.
  assign advance = !outValid || outReady;
  assign inReady = advance;

  logic [EXP_W-1:0] ea;
  logic [EXP_W-1:0] eb;
  logic [MAN_W-1:0] fa;
  logic [MAN_W-1:0] fb;
  fp_class_e        ca;
  fp_class_e        cb;

  assign ea = a[W-2:MAN_W];
  assign eb = b[W-2:MAN_W];
  assign fa = a[MAN_W-1:0];
  assign fb = b[MAN_W-1:0];
  assign ca = fp_classify(ea == '0, &ea, fa == '0);
  assign cb = fp_classify(eb == '0, &eb, fb == '0);

  logic             v1;
  logic             sign1;
  logic [EXP_W+1:0] exp1;
  fp_class_e        cls1;
  logic [MAN_W:0]   man_a1;
  logic [MAN_W:0]   man_b1;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      v1     <= 1'b0;
      sign1  <= 1'b0;
      exp1   <= '0;
      cls1   <= FP_ZERO;
      man_a1 <= '0;
      man_b1 <= '0;
    end else if (advance) begin
      v1     <= inValid;
      sign1  <= a[W-1] ^ b[W-1];
      exp1   <= {2'b00, ea} + {2'b00, eb} - BIAS;
      cls1   <= fp_mul_class(ca, cb);
      man_a1 <= {1'b1, fa};
      man_b1 <= {1'b1, fb};
    end
  end

  logic             v2;
  logic             sign2;
  logic [EXP_W+1:0] exp2;
  fp_class_e        cls2;
  logic [PW-1:0]    mprod2;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      v2     <= 1'b0;
      sign2  <= 1'b0;
      exp2   <= '0;
      cls2   <= FP_ZERO;
      mprod2 <= '0;
    end else if (advance) begin
      v2     <= v1;
      sign2  <= sign1;
      exp2   <= exp1;
      cls2   <= cls1;
      mprod2 <= PW'(man_a1) * PW'(man_b1);
    end
  end

  logic [W-1:0] r_product;
  logic         r_overflow;
  logic         r_underflow;
  logic         r_infinity;
  logic         r_nan;

  fp_norm_round #(
    .EXP_W(EXP_W),
    .MAN_W(MAN_W)
  ) u_norm_round (
    .mprod     (mprod2),
    .exp_sum   (exp2),
    .sign      (sign2),
    .cls       (cls2),
    .product   (r_product),
    .overflow  (r_overflow),
    .underflow (r_underflow),
    .infinity  (r_infinity),
    .nan       (r_nan)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      outValid  <= 1'b0;
      product   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      infinity  <= 1'b0;
      NAN       <= 1'b0;
    end else if (advance) begin
      outValid  <= v2;
      product   <= r_product;
      overflow  <= r_overflow;
      underflow <= r_underflow;
      infinity  <= r_infinity;
      NAN       <= r_nan;
    end
  end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Directed self-checking bench for fp_mult_pipe (EXP_W=8, MAN_W=23).
module tb_fp_mult_pipe;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        outValid;
  logic        outReady = 1'b1;
  logic [31:0] product;
  logic        overflow;
  logic        underflow;
  logic        infinity;
  logic        NAN;
  logic [3:0]  flags;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign flags = {NAN, infinity, overflow, underflow};

  fp_mult_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk       (clk),
    .resetN    (resetN),
    .inValid   (inValid),
    .inReady   (inReady),
    .a         (a),
    .b         (b),
    .outValid  (outValid),
    .outReady  (outReady),
    .product   (product),
    .overflow  (overflow),
    .underflow (underflow),
    .infinity  (infinity),
    .NAN       (NAN)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Single accepted pair with outReady held high; latency counted in cycles from presentation.
  task automatic run_one(input string tag, input logic [31:0] xa, input logic [31:0] xb,
                         input logic [31:0] xp, input logic [3:0] xf);
    int lat;
    @(negedge clk);
    a = xa;
    b = xb;
    inValid = 1'b1;
    #1;
    chk({tag, "_rdy"}, inReady, 1);
    @(negedge clk);
    inValid = 1'b0;
    lat = 1;
    while (!outValid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, lat, 3);
    chk({tag, "_prod"}, product, xp);
    chk({tag, "_flags"}, flags, xf);
  endtask

  logic [31:0] bp_a [5] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
  logic [31:0] bp_p [5] = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000, 32'h41200000};

`ifdef FP_MULT_RNE_EN
  localparam logic [31:0] EXP_RND = 32'h40100002;
`else
  localparam logic [31:0] EXP_RND = 32'h40100001;
`endif

  initial begin
    int sent;
    int got;
    int lat;
    int stale;

    #1;
    chk("rst_vld", outValid, 0);
    chk("rst_prod", product, 0);
    chk("rst_flags", flags, 0);
    chk("rst_rdy", inReady, 1);
    repeat (2) @(negedge clk);
    resetN = 1'b1;

    run_one("t1", 32'h42348000, 32'h3F800000, 32'h42348000, 4'b0000);

    @(negedge clk);
    a = 32'h40000000; b = 32'h40400000; inValid = 1'b1;
    @(negedge clk);
    a = 32'h40400000; b = 32'hC0000000;
    @(negedge clk);
    inValid = 1'b0;
    lat = 0;
    while (!outValid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("t2_vld1", outValid, 1);
    chk("t2_first", product, 32'h40C00000);
    @(negedge clk);
    chk("t2_vld2", outValid, 1);
    chk("t2_second", product, 32'hC0C00000);

    run_one("t3_nan", 32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000);
    run_one("t3_inf", 32'h7F800000, 32'hBF800000, 32'hFF800000, 4'b0100);
    run_one("t4_ovf", 32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0110);
    run_one("t4_unf", 32'h00800000, 32'h00800000, 32'h00000000, 4'b0001);
    run_one("t5_rnd", 32'h3FC00001, 32'h3FC00001, EXP_RND, 4'b0000);
    run_one("negzero", 32'h80000000, 32'h40000000, 32'h80000000, 4'b0000);
    run_one("qnan_in", 32'hFFC00001, 32'h3F800000, 32'h7FC00000, 4'b1000);

    sent = 0;
    got = 0;
    for (int cyc = 0; cyc < 60 && got < 5; cyc++) begin
      @(negedge clk);
      outReady = (cyc >= 8);
      inValid = (sent < 5);
      if (sent < 5) begin
        a = bp_a[sent];
        b = 32'h40000000;
      end
      #1;
      if (cyc == 6) begin
        chk("bp_stall_rdy", inReady, 0);
        chk("bp_stall_vld", outValid, 1);
        chk("bp_sent", sent, 3);
        chk("bp_hold", product, bp_p[0]);
      end
      if (outValid && outReady) begin
        chk($sformatf("bp_out%0d", got), product, bp_p[got]);
        got++;
      end
      if (inValid && inReady) sent++;
    end
    inValid = 1'b0;
    outReady = 1'b1;
    chk("bp_count", got, 5);
    repeat (3) @(negedge clk);
    chk("bp_no_dup", outValid, 0);

    @(negedge clk);
    a = 32'h40400000; b = 32'h40000000; inValid = 1'b1;
    repeat (3) @(negedge clk);
    inValid = 1'b0;
    #1;
    chk("rst_mid_pre", outValid, 1);
    resetN = 1'b0;
    #1;
    chk("rst_mid_vld", outValid, 0);
    chk("rst_mid_prod", product, 0);
    @(negedge clk);
    resetN = 1'b1;
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (outValid) stale++;
    end
    chk("rst_stale", stale, 0);

    run_one("post_rst", 32'h40400000, 32'h40400000, 32'h41100000, 4'b0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
